// File: rtl/pwr_clock_gate_ctrl.sv
// Per-channel clock-gating controller: RUN -> GATED after idle_thresh idle cycles, GATED -> WAKE on demand,
// WAKE -> RUN after WAKE_CYCLES settle cycles; registered outputs, saturating per-channel gate-event counters.
module pwr_clock_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       gate_allow,
  input  logic [IDLE_W-1:0]       idle_thresh,
  input  logic [NUM_CH-1:0]       activity,
  input  logic [NUM_CH-1:0]       wake_req,
  input  logic                    clr_stats,
  output logic [NUM_CH-1:0]       cg_en,
  output logic [NUM_CH-1:0]       ch_ready,
  output logic [NUM_CH-1:0]       gated,
  output logic [NUM_CH*CNT_W-1:0] gate_events
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_GATED = 2'd1,
    S_WAKE  = 2'd2
  } state_t;

  localparam int WK_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WK_W-1:0] WK_LAST = WK_W'(WAKE_CYCLES - 1);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nxt;
    logic [WK_W-1:0]   wake_cnt;
    logic [CNT_W-1:0]  ev_cnt;
    logic              wake_cond;
    logic              cg_r;
    logic              rdy_r;
    logic              gtd_r;

    assign wake_cond = activity[ch] | wake_req[ch] | ~gate_allow[ch];
    // idle_nxt includes the current cycle, so threshold N gates after exactly N idle cycles
    assign idle_nxt  = (&idle_cnt) ? idle_cnt : idle_cnt + 1'b1;

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= S_RUN;
        idle_cnt <= '0;
        wake_cnt <= '0;
        ev_cnt   <= '0;
        cg_r     <= 1'b1;
        rdy_r    <= 1'b1;
        gtd_r    <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            if (wake_cond) begin
              idle_cnt <= '0;
            end else if (idle_thresh != '0 && idle_nxt >= idle_thresh) begin
              state    <= S_GATED;
              idle_cnt <= '0;
              cg_r     <= 1'b0;
              rdy_r    <= 1'b0;
              gtd_r    <= 1'b1;
              if (!(&ev_cnt)) ev_cnt <= ev_cnt + 1'b1;
            end else begin
              idle_cnt <= idle_nxt;
            end
          end
          S_GATED: begin
            if (wake_cond) begin
              state    <= S_WAKE;
              wake_cnt <= '0;
              cg_r     <= 1'b1;
              rdy_r    <= 1'b0;
              gtd_r    <= 1'b0;
            end
          end
          S_WAKE: begin
            if (wake_cnt == WK_LAST) begin
              state    <= S_RUN;
              idle_cnt <= '0;
              wake_cnt <= '0;
              cg_r     <= 1'b1;
              rdy_r    <= 1'b1;
              gtd_r    <= 1'b0;
            end else begin
              wake_cnt <= wake_cnt + 1'b1;
            end
          end
          default: begin
            state    <= S_RUN;
            idle_cnt <= '0;
            wake_cnt <= '0;
            cg_r     <= 1'b1;
            rdy_r    <= 1'b1;
            gtd_r    <= 1'b0;
          end
        endcase
        // clear overrides any same-cycle increment above
        if (clr_stats) ev_cnt <= '0;
      end
    end

    assign cg_en[ch]                      = cg_r;
    assign ch_ready[ch]                   = rdy_r;
    assign gated[ch]                      = gtd_r;
    assign gate_events[ch*CNT_W +: CNT_W] = ev_cnt;
  end

endmodule
